// File: rtl/pit_prescale_pkg.sv
// Shared constants and divisor-code decode for the multi-channel PIT prescaler.
// Each code maps to a terminal count from the decade or binary table, saturating to the counter width.
package pit_prescale_pkg;

    localparam int CODE_W = 4;

    localparam logic [31:0] DECADE_TBL [16] = '{
        32'd1,     32'd2,     32'd4,     32'd8,
        32'd10,    32'd100,   32'd1000,  32'd10000,
        32'd20000, 32'd20000, 32'd20000, 32'd20000,
        32'd20000, 32'd20000, 32'd20000, 32'd20000
    };

    localparam logic [31:0] BINARY_TBL [16] = '{
        32'd1,     32'd2,     32'd4,     32'd8,
        32'd16,    32'd32,    32'd64,    32'd128,
        32'd256,   32'd512,   32'd1024,  32'd2048,
        32'd4096,  32'd8192,  32'd16384, 32'd32768
    };

    // Values that do not fit in count_size bits clamp to all-ones.
    function automatic logic [31:0] decode_code(
        input logic [CODE_W-1:0] code,
        input bit                decade,
        input int                count_size
    );
        logic [63:0] raw;
        logic [63:0] max_val;
        raw     = decade ? {32'd0, DECADE_TBL[code]} : {32'd0, BINARY_TBL[code]};
        max_val = (64'd1 << count_size) - 64'd1;
        if (raw > max_val) begin
            raw = max_val;
        end
        return raw[31:0];
    endfunction

endpackage

// File: rtl/pit_prescale_chan.sv
// One prescaler channel: sync mux, period counter and double-buffered terminal count.
// Direct divide input exists only when PIT_PRESCALE_DIRECT_EN is defined.
module pit_prescale_chan
    import pit_prescale_pkg::*;
#(
    parameter int COUNT_SIZE  = 16,
    parameter int DECADE_CNTR = 1
) (
    input  logic                  bus_clk,
    input  logic                  async_rst,
    input  logic                  cnt_sync_i,
    input  logic                  ext_sync_i,
    input  logic                  pit_slave,
    input  logic                  div_load,
    input  logic [CODE_W-1:0]     divisor,
`ifdef PIT_PRESCALE_DIRECT_EN
    input  logic                  div_direct,
    input  logic [COUNT_SIZE-1:0] div_val,
`endif
    output logic                  prescale_out,
    output logic                  counter_sync,
    output logic                  div_pending
);

    logic [COUNT_SIZE-1:0] cnt_q, cnt_d;
    logic [COUNT_SIZE-1:0] end_act_q, end_act_d;
    logic [COUNT_SIZE-1:0] end_pend_q, end_pend_d;
    logic                  pend_v_q, pend_v_d;

    logic [COUNT_SIZE-1:0] table_val;
    logic [COUNT_SIZE-1:0] load_val;
    logic                  rollover;
    logic                  apply;

    always_comb begin
        table_val = COUNT_SIZE'(decode_code(divisor, DECADE_CNTR != 0, COUNT_SIZE));
        load_val  = table_val;
`ifdef PIT_PRESCALE_DIRECT_EN
        if (div_direct) begin
            load_val = (div_val == '0) ? COUNT_SIZE'(1) : div_val;
        end
`endif
    end

    always_comb begin
        counter_sync = pit_slave ? ext_sync_i : cnt_sync_i;
        rollover     = (cnt_q == end_act_q);
        prescale_out = counter_sync && rollover && !async_rst;
        div_pending  = pend_v_q;
    end

    // The shadow is applied only on a period boundary or an idle cycle, so a count in progress is never cut short.
    always_comb begin
        apply      = pend_v_q && (rollover || !counter_sync);
        cnt_d      = (!counter_sync || rollover) ? COUNT_SIZE'(1) : cnt_q + COUNT_SIZE'(1);
        end_act_d  = apply ? end_pend_q : end_act_q;
        end_pend_d = end_pend_q;
        pend_v_d   = pend_v_q;
        if (apply) begin
            pend_v_d = 1'b0;
        end
        if (div_load) begin
            end_pend_d = load_val;
            pend_v_d   = 1'b1;
        end
    end

    always_ff @(posedge bus_clk or posedge async_rst) begin
        if (async_rst) begin
            cnt_q      <= COUNT_SIZE'(1);
            end_act_q  <= COUNT_SIZE'(1);
            end_pend_q <= COUNT_SIZE'(1);
            pend_v_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            end_act_q  <= end_act_d;
            end_pend_q <= end_pend_d;
            pend_v_q   <= pend_v_d;
        end
    end

endmodule

// File: rtl/pit_prescale_mc.sv
// Multi-channel PIT prescaler top: one pit_prescale_chan per channel on sliced buses.
// Define PIT_PRESCALE_DIRECT_EN to add the div_direct/div_val arbitrary-divide ports.
module pit_prescale_mc
    import pit_prescale_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int COUNT_SIZE  = 16,
    parameter int DECADE_CNTR = 1
) (
    input  logic                           bus_clk,
    input  logic                           async_rst,
    input  logic [CHANNELS-1:0]            cnt_sync_i,
    input  logic [CHANNELS-1:0]            ext_sync_i,
    input  logic [CHANNELS-1:0]            pit_slave,
    input  logic [CHANNELS-1:0]            div_load,
    input  logic [CODE_W*CHANNELS-1:0]     divisor,
`ifdef PIT_PRESCALE_DIRECT_EN
    input  logic [CHANNELS-1:0]            div_direct,
    input  logic [COUNT_SIZE*CHANNELS-1:0] div_val,
`endif
    output logic [CHANNELS-1:0]            prescale_out,
    output logic [CHANNELS-1:0]            counter_sync,
    output logic [CHANNELS-1:0]            div_pending
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pit_prescale_chan #(
            .COUNT_SIZE  (COUNT_SIZE),
            .DECADE_CNTR (DECADE_CNTR)
        ) u_chan (
            .bus_clk      (bus_clk),
            .async_rst    (async_rst),
            .cnt_sync_i   (cnt_sync_i[g]),
            .ext_sync_i   (ext_sync_i[g]),
            .pit_slave    (pit_slave[g]),
            .div_load     (div_load[g]),
            .divisor      (divisor[g*CODE_W +: CODE_W]),
`ifdef PIT_PRESCALE_DIRECT_EN
            .div_direct   (div_direct[g]),
            .div_val      (div_val[g*COUNT_SIZE +: COUNT_SIZE]),
`endif
            .prescale_out (prescale_out[g]),
            .counter_sync (counter_sync[g]),
            .div_pending  (div_pending[g])
        );
    end

endmodule

// File: tb/tb_pit_prescale_mc.sv
// Scoreboard bench for pit_prescale_mc: a cycle-level model of each channel's period predicts outputs.
// Direct-mode stimulus is included when PIT_PRESCALE_DIRECT_EN is defined.
module tb_pit_prescale_mc;

    localparam int CH = 4;
    localparam int CS = 16;

    logic              bus_clk = 1'b0;
    logic              async_rst;
    logic [CH-1:0]     cnt_sync_i;
    logic [CH-1:0]     ext_sync_i;
    logic [CH-1:0]     pit_slave;
    logic [CH-1:0]     div_load;
    logic [4*CH-1:0]   divisor;
`ifdef PIT_PRESCALE_DIRECT_EN
    logic [CH-1:0]     div_direct;
    logic [CS*CH-1:0]  div_val;
`endif
    logic [CH-1:0]     prescale_out;
    logic [CH-1:0]     counter_sync;
    logic [CH-1:0]     div_pending;

    pit_prescale_mc #(.CHANNELS(CH), .COUNT_SIZE(CS), .DECADE_CNTR(1)) dut (
        .bus_clk      (bus_clk),
        .async_rst    (async_rst),
        .cnt_sync_i   (cnt_sync_i),
        .ext_sync_i   (ext_sync_i),
        .pit_slave    (pit_slave),
        .div_load     (div_load),
        .divisor      (divisor),
`ifdef PIT_PRESCALE_DIRECT_EN
        .div_direct   (div_direct),
        .div_val      (div_val),
`endif
        .prescale_out (prescale_out),
        .counter_sync (counter_sync),
        .div_pending  (div_pending)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct {
        logic [CH-1:0] ps;
        logic [CH-1:0] cs;
        logic [CH-1:0] dp;
    } exp_t;

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    bit   win_en        = 1'b0;
    int   win_pulses    = 0;

    // Model: cycles left until the next pulse, current period, and an optional waiting period.
    int rem      [CH];
    int per      [CH];
    int pend_per [CH];
    bit pend     [CH];

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            rem[k] = 1; per[k] = 1; pend_per[k] = 1; pend[k] = 1'b0;
        end
    endtask

    function automatic int ref_div(input int k);
        int dec_vals [9] = '{1, 2, 4, 8, 10, 100, 1000, 10000, 20000};
        int code;
        int v;
        code = int'(divisor[4*k +: 4]);
        v = (code > 8) ? 20000 : dec_vals[code];
`ifdef PIT_PRESCALE_DIRECT_EN
        if (div_direct[k]) begin
            v = int'(div_val[CS*k +: CS]);
            if (v == 0) v = 1;
        end
`endif
        if (v > (1 << CS) - 1) v = (1 << CS) - 1;
        return v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Predict this cycle's outputs from current inputs, advance the model, then cross the clock edge.
    task automatic apply_stimulus();
        exp_t          e;
        logic [CH-1:0] sy;
        bit            pulse;
        bit            app;
        int            nv;
        sy = (pit_slave & ext_sync_i) | (~pit_slave & cnt_sync_i);
        e.cs = sy;
        for (int k = 0; k < CH; k++) begin
            e.ps[k] = !async_rst && sy[k] && (rem[k] == 1);
            e.dp[k] = !async_rst && pend[k];
        end
        exp_q.push_back(e);
        if (async_rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < CH; k++) begin
                pulse = sy[k] && (rem[k] == 1);
                nv    = ref_div(k);
                app   = pend[k] && (pulse || !sy[k]);
                if (app) per[k] = pend_per[k];
                if (!sy[k] || pulse) rem[k] = per[k];
                else rem[k] = rem[k] - 1;
                if (div_load[k]) begin
                    pend_per[k] = nv;
                    pend[k]     = 1'b1;
                end else if (app) begin
                    pend[k] = 1'b0;
                end
            end
        end
        @(posedge bus_clk);
        #1;
        div_load = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic load_code(input int k, input int code);
        divisor[4*k +: 4] = 4'(code);
        div_load[k] = 1'b1;
    endtask

    always @(negedge bus_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("prescale_out", int'(prescale_out), int'(e.ps));
            check_output("counter_sync", int'(counter_sync), int'(e.cs));
            check_output("div_pending",  int'(div_pending),  int'(e.dp));
            if (win_en && prescale_out[1]) win_pulses++;
        end
    end

    initial begin
        async_rst  = 1'b1;
        cnt_sync_i = '0;
        ext_sync_i = '0;
        pit_slave  = '0;
        div_load   = '0;
        divisor    = '0;
`ifdef PIT_PRESCALE_DIRECT_EN
        div_direct = '0;
        div_val    = '0;
`endif
        model_reset();
        @(posedge bus_clk);
        #1;
        run(3);
        async_rst = 1'b0;

        // Code 0 passes sync straight through, then code 3 on channel 0 gives divide-by-8.
        cnt_sync_i = '1;
        run(5);
        load_code(0, 3);
        run(30);

        // Decade code 5 on channel 1: exactly ten pulses in a 1000-cycle window.
        load_code(1, 5);
        cnt_sync_i[1] = 1'b0;
        run(1);
        cnt_sync_i[1] = 1'b1;
        win_en = 1'b1;
        run(1000);
        win_en = 1'b0;
        check_output("decade_100_pulse_count", win_pulses, 10);

        // Channel 2 at 10000, reloaded mid-period with code 4.
        load_code(2, 7);
        cnt_sync_i[2] = 1'b0;
        run(1);
        cnt_sync_i[2] = 1'b1;
        run(4999);
        load_code(2, 4);
        run(5030);

        // Slave pass-through on channel 3 ignores cnt_sync_i.
        pit_slave[3] = 1'b1;
        foreach (ext_sync_i[i]) ext_sync_i[i] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ext_sync_i[3] = (i % 4) != 1;
            cnt_sync_i[3] = 1'($urandom_range(0, 1));
            run(1);
        end

        // Sync drop at count 3 of 8 with a load waiting.
        cnt_sync_i[0] = 1'b0;
        run(1);
        cnt_sync_i[0] = 1'b1;
        run(1);
        load_code(0, 2);
        run(1);
        cnt_sync_i[0] = 1'b0;
        run(1);
        cnt_sync_i[0] = 1'b1;
        run(12);

`ifdef PIT_PRESCALE_DIRECT_EN
        pit_slave[3]  = 1'b0;
        cnt_sync_i[3] = 1'b1;
        div_direct[3] = 1'b1;
        div_val[CS*3 +: CS] = '0;
        div_load[3] = 1'b1;
        run(6);
        div_val[CS*3 +: CS] = 16'd13;
        div_load[3] = 1'b1;
        run(45);
`endif

        // Randomised traffic, including unloaded divisor changes and short resets.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < CH; k++) begin
                cnt_sync_i[k] = $urandom_range(0, 7) != 0;
                ext_sync_i[k] = $urandom_range(0, 5) != 0;
                if ($urandom_range(0, 63) == 0) pit_slave[k] = ~pit_slave[k];
                divisor[4*k +: 4] = 4'($urandom_range(0, 5));
                div_load[k] = $urandom_range(0, 40) == 0;
`ifdef PIT_PRESCALE_DIRECT_EN
                div_direct[k] = $urandom_range(0, 2) == 0;
                div_val[CS*k +: CS] = 16'($urandom_range(0, 20));
`endif
            end
            async_rst = $urandom_range(0, 499) == 0;
            run(1);
        end
        async_rst = 1'b0;

        // Reset asserted mid-period with loads pending, then restart.
        cnt_sync_i = '1;
        pit_slave  = '0;
        div_load   = '1;
        run(3);
        async_rst = 1'b1;
        run(2);
        async_rst = 1'b0;
        run(20);

        @(negedge bus_clk);
        #1;
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
